// File: rtl/crypto_csr_pkg.sv
// rtl/crypto_csr_pkg.sv - shared state enum, CTRL/STATUS bit indices and address-map helpers
package crypto_csr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int CTRL_START   = 0;
   localparam int CTRL_CLEAR   = 1;
   localparam int CTRL_ABORT   = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_OVERRUN = 2;

   localparam int KEY_BASE     = 0;

   function automatic int msg_in_base(input int k);
      return k;
   endfunction

   function automatic int msg_out_base(input int k, input int m);
      return k + m;
   endfunction

   function automatic int ctrl_addr(input int k, input int m);
      return k + 2 * m;
   endfunction

   function automatic int status_addr(input int k, input int m);
      return k + 2 * m + 1;
   endfunction

   function automatic int cycles_addr(input int k, input int m);
      return k + 2 * m + 2;
   endfunction

endpackage

// File: rtl/avalon_crypto_csr_if.sv
// rtl/avalon_crypto_csr_if.sv - Avalon-MM slave bus bundle for the crypto CSR bank
interface avalon_crypto_csr_if #(
   parameter int ADDR_W = 4
);
   logic              AVL_READ;
   logic              AVL_WRITE;
   logic              AVL_CS;
   logic [3:0]        AVL_BYTE_EN;
   logic [ADDR_W-1:0] AVL_ADDR;
   logic [31:0]       AVL_WRITEDATA;
   logic [31:0]       AVL_READDATA;

   modport master (
      output AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
      input  AVL_READDATA
   );

   modport slave (
      input  AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
      output AVL_READDATA
   );
endinterface

// File: rtl/csr_byte_reg.sv
// rtl/csr_byte_reg.sv - 32-bit register with per-byte write enables and async reset
module csr_byte_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [3:0]  byte_en,
   input  logic [31:0] wdata,
   output logic [31:0] q
);

   logic [31:0] data_q;
   logic [31:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               data_d[8*b +: 8] = wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/avalon_crypto_csr.sv
// rtl/avalon_crypto_csr.sv - Avalon-MM register bank and start/done/abort control for a cipher core
module avalon_crypto_csr
   import crypto_csr_pkg::*;
#(
   parameter int KEY_WORDS = 4,
   parameter int MSG_WORDS = 4,
   parameter int ADDR_W    = $clog2(KEY_WORDS + 2 * MSG_WORDS + 3)
) (
   input  logic                   CLK,
   input  logic                   RESET,
   avalon_crypto_csr_if.slave     avl,
   output logic                   CORE_START,
   input  logic                   CORE_DONE,
   output logic [32*KEY_WORDS-1:0] CORE_KEY,
   output logic [32*MSG_WORDS-1:0] CORE_MSG_IN,
   input  logic [32*MSG_WORDS-1:0] CORE_MSG_OUT,
   output logic [31:0]            EXPORT_DATA
);

   localparam int NREG     = KEY_WORDS + MSG_WORDS;
   localparam int MIN_BASE = msg_in_base(KEY_WORDS);
   localparam int OUT_BASE = msg_out_base(KEY_WORDS, MSG_WORDS);
   localparam int CTRL_A   = ctrl_addr(KEY_WORDS, MSG_WORDS);
   localparam int STAT_A   = status_addr(KEY_WORDS, MSG_WORDS);
   localparam int CYC_A    = cycles_addr(KEY_WORDS, MSG_WORDS);

   logic [ADDR_W-1:0] addr;
   logic [31:0]       addr_w;
   logic              wr_en;
   logic              rd_en;
   logic              ctrl_wr;
   logic              start_w;
   logic              clear_w;
   logic              abort_w;
   logic              in_run;

   state_e                 state_q, state_d;
   logic                   overrun_q, overrun_d;
   logic [31:0]            cycles_q, cycles_d;
   logic [32*MSG_WORDS-1:0] msg_out_q, msg_out_d;
   logic [31:0]            rdata_q, rdata_d;
   logic [31:0]            rd_val;
   logic [31:0]            status_word;
   logic [31:0]            reg_words [NREG];

   assign addr    = avl.AVL_ADDR;
   assign addr_w  = 32'(addr);
   assign wr_en   = avl.AVL_WRITE && avl.AVL_CS;
   assign rd_en   = avl.AVL_READ && avl.AVL_CS;
   assign in_run  = (state_q == ST_RUN);
   assign ctrl_wr = wr_en && avl.AVL_BYTE_EN[0] && (addr_w == 32'(CTRL_A));
   assign start_w = ctrl_wr && avl.AVL_WRITEDATA[CTRL_START];
   assign clear_w = ctrl_wr && avl.AVL_WRITEDATA[CTRL_CLEAR];
   assign abort_w = ctrl_wr && avl.AVL_WRITEDATA[CTRL_ABORT];

   // Key and msg_in share one register array; operands are frozen while the core runs.
   for (genvar i = 0; i < NREG; i++) begin : g_reg
      csr_byte_reg u_reg (
         .clk     (CLK),
         .rst     (RESET),
         .load    (wr_en && !in_run && (addr_w == 32'(KEY_BASE + i))),
         .byte_en (avl.AVL_BYTE_EN),
         .wdata   (avl.AVL_WRITEDATA),
         .q       (reg_words[i])
      );
      if (i < KEY_WORDS) begin : g_key
         assign CORE_KEY[32*i +: 32] = reg_words[i];
      end else begin : g_msg
         assign CORE_MSG_IN[32*(i-KEY_WORDS) +: 32] = reg_words[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      overrun_d = overrun_q;
      cycles_d  = cycles_q;
      msg_out_d = msg_out_q;
      if (clear_w) begin
         overrun_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (start_w) begin
               state_d  = ST_RUN;
               cycles_d = '0;
            end
         end
         ST_RUN: begin
            if (cycles_q != 32'hFFFF_FFFF) begin
               cycles_d = cycles_q + 32'd1;
            end
            if (start_w) begin
               overrun_d = 1'b1;
            end
            // A result arriving with ABORT is still captured.
            if (CORE_DONE) begin
               msg_out_d = CORE_MSG_OUT;
               state_d   = ST_DONE;
            end else if (abort_w) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (start_w) begin
               state_d  = ST_RUN;
               cycles_d = '0;
            end else if (clear_w) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      status_word               = '0;
      status_word[STAT_BUSY]    = (state_q == ST_RUN);
      status_word[STAT_DONE]    = (state_q == ST_DONE);
      status_word[STAT_OVERRUN] = overrun_q;
      rd_val = '0;
      for (int i = 0; i < NREG; i++) begin
         if (addr_w == 32'(KEY_BASE + i)) rd_val = reg_words[i];
      end
      for (int j = 0; j < MSG_WORDS; j++) begin
         if (addr_w == 32'(OUT_BASE + j)) rd_val = msg_out_q[32*j +: 32];
      end
      if (addr_w == 32'(STAT_A)) rd_val = status_word;
      if (addr_w == 32'(CYC_A))  rd_val = cycles_q;
      rdata_d = rd_en ? rd_val : rdata_q;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         overrun_q <= 1'b0;
         cycles_q  <= '0;
         msg_out_q <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         overrun_q <= overrun_d;
         cycles_q  <= cycles_d;
         msg_out_q <= msg_out_d;
         rdata_q   <= rdata_d;
      end
   end

   assign avl.AVL_READDATA = rdata_q;
   assign CORE_START       = in_run;
   assign EXPORT_DATA      = {reg_words[NREG-1][31:16], reg_words[MIN_BASE][15:0]};

endmodule
